// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: operand forwarding,
// stall/flush generation, MDU busy-window sequencing and a saturating stall counter.
module hazard_fwd_ctrl #(
  parameter int unsigned MDU_LAT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       write_reg_e,
  input  logic [4:0]       write_reg_m,
  input  logic [4:0]       write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             pc_src_d,
  input  logic             jump_d,
  input  logic             hilo_read_d,
  input  logic             mdu_start_d,
  input  logic             mdu_start_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          m_rs_e, w_rs_e, m_rt_e, w_rt_e;
  logic          m_rs_d, m_rt_d, e_rs_d, e_rt_d;
  logic          lw_stall, br_stall, hilo_stall, stall;
  logic [1:0]    fwd_a, fwd_b;

  // A stage supplies register r only if it writes a non-zero destination equal to r.
  function automatic logic match(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return we && (wr != 5'd0) && (wr == r);
  endfunction

  always_comb begin
    m_rs_e = match(reg_write_m, write_reg_m, rs_e);
    w_rs_e = match(reg_write_w, write_reg_w, rs_e);
    m_rt_e = match(reg_write_m, write_reg_m, rt_e);
    w_rt_e = match(reg_write_w, write_reg_w, rt_e);
    m_rs_d = match(reg_write_m, write_reg_m, rs_d);
    m_rt_d = match(reg_write_m, write_reg_m, rt_d);
    e_rs_d = match(reg_write_e, write_reg_e, rs_d);
    e_rt_d = match(reg_write_e, write_reg_e, rt_d);
  end

  // M has priority over W; code 2'b11 is unreachable.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (m_rs_e)      fwd_a = 2'b10;
    else if (w_rs_e) fwd_a = 2'b01;
    if (m_rt_e)      fwd_b = 2'b10;
    else if (w_rt_e) fwd_b = 2'b01;
  end

  always_comb begin
    lw_stall   = mem_to_reg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));
    br_stall   = branch_d && (e_rs_d || e_rt_d || (mem_to_reg_m && (m_rs_d || m_rt_d)));
    hilo_stall = (hilo_read_d || mdu_start_d) && ((state == BUSY) || mdu_start_e);
    stall      = lw_stall || br_stall || hilo_stall;
  end

  // Everything is held at zero while reset is asserted, combinational paths included.
  always_comb begin
    forward_a_e = rst_n ? fwd_a : 2'b00;
    forward_b_e = rst_n ? fwd_b : 2'b00;
    forward_a_d = rst_n && m_rs_d;
    forward_b_d = rst_n && m_rt_d;
    stall_f     = rst_n && stall;
    stall_d     = rst_n && stall;
    flush_e     = rst_n && stall;
    flush_d     = rst_n && (pc_src_d || jump_d) && !stall;
    mdu_busy    = rst_n && (state == BUSY);
  end

  // MDU window: busy for MDU_LAT cycles after the issue cycle; re-issue while busy is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start_e) begin
            state <= BUSY;
            cnt   <= CW'(MDU_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
